// File: rtl/scr1_dmem_router_pkg.sv
// Shared types and default address map for the data-memory router.
package scr1_dmem_router_pkg;

  localparam int unsigned SCR1_DMEM_AWIDTH = 32;
  localparam int unsigned YTYDLA_LSU_WIDTH = 32;
  localparam int unsigned SCR1_DMEM_SEL_W  = 2;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'd0,
    SCR1_MEM_WIDTH_HWORD = 2'd1,
    SCR1_MEM_WIDTH_WORD  = 2'd2,
    SCR1_MEM_WIDTH_ERROR = 2'd3
  } type_scr1_mem_y_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_IDLE   = 2'd0,
    SCR1_MEM_RESP_RDY_OK = 2'd1,
    SCR1_MEM_RESP_RDY_ER = 2'd2
  } type_scr1_mem_resp_e;

  typedef enum logic [1:0] {
    SCR1_DMEM_FSM_ADDR = 2'd0,
    SCR1_DMEM_FSM_DATA = 2'd1,
    SCR1_DMEM_FSM_ERR  = 2'd2
  } type_scr1_dmem_fsm_e;

  typedef logic [SCR1_DMEM_SEL_W-1:0] type_scr1_dmem_sel_t;

  localparam logic [SCR1_DMEM_AWIDTH-1:0] SCR1_DMEM_PORT_BASE_DEF [3] =
    '{32'h0000_0000, 32'hF000_0000, 32'hF004_0000};
  localparam logic [SCR1_DMEM_AWIDTH-1:0] SCR1_DMEM_PORT_MASK_DEF [3] =
    '{32'h0000_0000, 32'hFFFF_0000, 32'hFFFF_0000};

endpackage

// File: rtl/scr1_dmem_addr_decoder.sv
// Maps a request address to the lowest-index port whose base/mask window contains it.
module scr1_dmem_addr_decoder
  import scr1_dmem_router_pkg::*;
#(
  parameter int unsigned PORT_NUM = 3,
  parameter logic [SCR1_DMEM_AWIDTH-1:0] PORT_ADDR_BASE [PORT_NUM] = SCR1_DMEM_PORT_BASE_DEF,
  parameter logic [SCR1_DMEM_AWIDTH-1:0] PORT_ADDR_MASK [PORT_NUM] = SCR1_DMEM_PORT_MASK_DEF
) (
  input  logic [SCR1_DMEM_AWIDTH-1:0] addr_i,
  output type_scr1_dmem_sel_t         sel_o,
  output logic                        hit_o
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    sel_o = '0;
    hit_o = 1'b0;
    for (int i = int'(PORT_NUM) - 1; i >= 0; i--) begin
      if ((addr_i & PORT_ADDR_MASK[i]) == PORT_ADDR_BASE[i]) begin
        sel_o = SCR1_DMEM_SEL_W'(i);
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scr1_dmem_router_np.sv
// Routes core data-memory requests to one of PORT_NUM downstream ports by address,
// with one transaction outstanding and an error response for unmapped addresses.
module scr1_dmem_router_np
  import scr1_dmem_router_pkg::*;
#(
  parameter int unsigned PORT_NUM = 3,
  parameter logic [SCR1_DMEM_AWIDTH-1:0] PORT_ADDR_BASE [PORT_NUM] = SCR1_DMEM_PORT_BASE_DEF,
  parameter logic [SCR1_DMEM_AWIDTH-1:0] PORT_ADDR_MASK [PORT_NUM] = SCR1_DMEM_PORT_MASK_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dmem_req,
  input  type_scr1_mem_cmd_e            dmem_cmd,
  input  type_scr1_mem_y_width_e        dmem_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0]   dmem_addr,
  input  logic [YTYDLA_LSU_WIDTH-1:0]   dmem_wdata,
  output logic                          dmem_req_ack,
  output logic [YTYDLA_LSU_WIDTH-1:0]   dmem_rdata,
  output type_scr1_mem_resp_e           dmem_resp,
  output logic [PORT_NUM-1:0]           port_req,
  output type_scr1_mem_cmd_e            port_cmd   [PORT_NUM],
  output type_scr1_mem_y_width_e        port_width [PORT_NUM],
  output logic [SCR1_DMEM_AWIDTH-1:0]   port_addr  [PORT_NUM],
  output logic [YTYDLA_LSU_WIDTH-1:0]   port_wdata [PORT_NUM],
  input  logic [PORT_NUM-1:0]           port_req_ack,
  input  logic [YTYDLA_LSU_WIDTH-1:0]   port_rdata [PORT_NUM],
  input  type_scr1_mem_resp_e           port_resp  [PORT_NUM]
);

  type_scr1_dmem_fsm_e state_q;
  type_scr1_dmem_sel_t port_sel_q;
  type_scr1_dmem_sel_t dec_sel;
  logic                dec_hit;
  type_scr1_mem_resp_e cur_resp;
  logic                accept_win;
  logic                accept;

  scr1_dmem_addr_decoder #(
    .PORT_NUM       (PORT_NUM),
    .PORT_ADDR_BASE (PORT_ADDR_BASE),
    .PORT_ADDR_MASK (PORT_ADDR_MASK)
  ) u_decoder (
    .addr_i (dmem_addr),
    .sel_o  (dec_sel),
    .hit_o  (dec_hit)
  );

  for (genvar g = 0; g < PORT_NUM; g++) begin : g_bcast
    assign port_cmd[g]   = dmem_cmd;
    assign port_width[g] = dmem_width;
    assign port_addr[g]  = dmem_addr;
    assign port_wdata[g] = dmem_wdata;
  end

  assign cur_resp   = port_resp[port_sel_q];
  // A new request may be taken when idle or while the current one completes OK.
  assign accept_win = (state_q == SCR1_DMEM_FSM_ADDR) ||
                      ((state_q == SCR1_DMEM_FSM_DATA) && (cur_resp == SCR1_MEM_RESP_RDY_OK));
  assign accept     = dmem_req && dmem_req_ack;

  always_comb begin
    port_req     = '0;
    dmem_req_ack = 1'b0;
    dmem_resp    = SCR1_MEM_RESP_IDLE;
    dmem_rdata   = '0;
    if (accept_win) begin
      dmem_req_ack = dec_hit ? port_req_ack[dec_sel] : 1'b1;
      if (dec_hit && !rst) port_req[dec_sel] = dmem_req;
    end
    case (state_q)
      SCR1_DMEM_FSM_DATA: begin
        dmem_resp  = cur_resp;
        dmem_rdata = port_rdata[port_sel_q];
      end
      SCR1_DMEM_FSM_ERR:  dmem_resp = SCR1_MEM_RESP_RDY_ER;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SCR1_DMEM_FSM_ADDR;
      port_sel_q <= '0;
    end else if (accept) begin
      state_q <= dec_hit ? SCR1_DMEM_FSM_DATA : SCR1_DMEM_FSM_ERR;
      if (dec_hit) port_sel_q <= dec_sel;
    end else begin
      case (state_q)
        SCR1_DMEM_FSM_ADDR: ;
        SCR1_DMEM_FSM_DATA: if (cur_resp != SCR1_MEM_RESP_IDLE) state_q <= SCR1_DMEM_FSM_ADDR;
        default:            state_q <= SCR1_DMEM_FSM_ADDR;
      endcase
    end
  end

  a_dmem_ctrl_known: assert property (@(posedge clk) disable iff (rst)
    dmem_req |-> !$isunknown({dmem_cmd, dmem_width}));

endmodule

// File: tb/tb_scr1_dmem_router_np.sv
// Bench for scr1_dmem_router_np: directed scenarios plus random traffic against a transaction model.
module tb_scr1_dmem_router_np;
  import scr1_dmem_router_pkg::*;

  localparam int unsigned NP = 3;
  // Port0 = low 256MB, port1 = 0xF000_xxxx, port2 = 0xF00x_xxxx (overlaps port1).
  localparam logic [31:0] MAP_BASE [NP] = '{32'h0000_0000, 32'hF000_0000, 32'hF000_0000};
  localparam logic [31:0] MAP_MASK [NP] = '{32'hF000_0000, 32'hFFFF_0000, 32'hFFF0_0000};

  logic                   clk;
  logic                   rst;
  logic                   dmem_req;
  type_scr1_mem_cmd_e     dmem_cmd;
  type_scr1_mem_y_width_e dmem_width;
  logic [31:0]            dmem_addr;
  logic [31:0]            dmem_wdata;
  logic                   dmem_req_ack;
  logic [31:0]            dmem_rdata;
  type_scr1_mem_resp_e    dmem_resp;
  logic [NP-1:0]          port_req;
  type_scr1_mem_cmd_e     port_cmd   [NP];
  type_scr1_mem_y_width_e port_width [NP];
  logic [31:0]            port_addr  [NP];
  logic [31:0]            port_wdata [NP];
  logic [NP-1:0]          port_req_ack;
  logic [31:0]            port_rdata [NP];
  type_scr1_mem_resp_e    port_resp  [NP];

  scr1_dmem_router_np #(
    .PORT_NUM       (NP),
    .PORT_ADDR_BASE (MAP_BASE),
    .PORT_ADDR_MASK (MAP_MASK)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dmem_req     (dmem_req),
    .dmem_cmd     (dmem_cmd),
    .dmem_width   (dmem_width),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_req_ack (dmem_req_ack),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .port_req     (port_req),
    .port_cmd     (port_cmd),
    .port_width   (port_width),
    .port_addr    (port_addr),
    .port_wdata   (port_wdata),
    .port_req_ack (port_req_ack),
    .port_rdata   (port_rdata),
    .port_resp    (port_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction model: is a port transaction or an error response pending, and for which port.
  bit m_busy;
  bit m_err;
  int m_port;

  int                  mt;
  bit                  win;
  logic [NP-1:0]       e_preq;
  logic                e_ack;
  type_scr1_mem_resp_e e_resp;
  logic [31:0]         e_rdata;

  function automatic int target(input logic [31:0] a);
    for (int i = 0; i < int'(NP); i++)
      if ((a & MAP_MASK[i]) == MAP_BASE[i]) return i;
    return -1;
  endfunction

  always_comb begin
    mt      = target(dmem_addr);
    win     = !m_err && (!m_busy || port_resp[m_port] == SCR1_MEM_RESP_RDY_OK);
    e_preq  = '0;
    if (win && !rst && dmem_req && mt >= 0) e_preq[mt] = 1'b1;
    e_ack   = win && ((mt < 0) ? 1'b1 : port_req_ack[mt]);
    e_resp  = m_err ? SCR1_MEM_RESP_RDY_ER : (m_busy ? port_resp[m_port] : SCR1_MEM_RESP_IDLE);
    e_rdata = m_busy ? port_rdata[m_port] : 32'h0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model mid-cycle.
  task automatic settle();
    logic bc_ok;
    @(negedge clk);
    chk("port_req", 32'(port_req), 32'(e_preq));
    chk("req_ack", 32'(dmem_req_ack), 32'(e_ack));
    chk("resp", 32'(dmem_resp), 32'(e_resp));
    chk("rdata", dmem_rdata, e_rdata);
    bc_ok = 1'b1;
    for (int i = 0; i < int'(NP); i++)
      if (port_addr[i] !== dmem_addr || port_wdata[i] !== dmem_wdata ||
          port_cmd[i] !== dmem_cmd || port_width[i] !== dmem_width) bc_ok = 1'b0;
    chk("broadcast", 32'(bc_ok), 32'd1);
  endtask

  // Advance the model across the clock edge, then step off the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (m_err) m_err = 1'b0;
      else if (win && dmem_req && e_ack) begin
        if (mt >= 0) begin m_busy = 1'b1; m_port = mt; end
        else begin m_busy = 1'b0; m_err = 1'b1; end
      end else if (m_busy && port_resp[m_port] != SCR1_MEM_RESP_IDLE) m_busy = 1'b0;
    end
    #1;
  endtask

  task automatic req(input logic r, input logic [31:0] a, input type_scr1_mem_cmd_e c);
    dmem_req   = r;
    dmem_addr  = a;
    dmem_cmd   = c;
    dmem_width = SCR1_MEM_WIDTH_WORD;
    dmem_wdata = a ^ 32'h5A5A_5A5A;
  endtask

  task automatic ports_idle();
    port_req_ack = '0;
    for (int i = 0; i < int'(NP); i++) begin
      port_resp[i]  = SCR1_MEM_RESP_IDLE;
      port_rdata[i] = 32'h0;
    end
  endtask

  function automatic type_scr1_mem_resp_e rand_resp();
    int unsigned r = $urandom_range(0, 19);
    if (r < 10) return SCR1_MEM_RESP_IDLE;
    if (r < 17) return SCR1_MEM_RESP_RDY_OK;
    return SCR1_MEM_RESP_RDY_ER;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return {4'h0, 28'($urandom)};
      1:       return {16'hF000, 16'($urandom)};
      2:       return {12'hF00, 20'($urandom)};
      default: return {4'hE, 28'($urandom)};
    endcase
  endfunction

  initial begin
    m_busy = 1'b0; m_err = 1'b0; m_port = 0;
    rst = 1'b1;
    ports_idle();
    req(1'b0, 32'h0000_0100, SCR1_MEM_CMD_RD);

    // Reset state
    settle();
    chk("rst_preq", 32'(port_req), 32'h0);
    chk("rst_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_IDLE));
    req(1'b1, 32'h0000_0100, SCR1_MEM_CMD_RD);
    port_req_ack = 3'b001;
    settle();
    chk("rst_preq_blocked", 32'(port_req), 32'h0);
    chk("rst_ack_mapped", 32'(dmem_req_ack), 32'd1);
    req(1'b1, 32'hE000_0000, SCR1_MEM_CMD_RD);
    port_req_ack = '0;
    settle();
    chk("rst_ack_unmapped", 32'(dmem_req_ack), 32'd1);
    tick();
    rst = 1'b0;

    // Single read on port0, first posedge after reset release
    req(1'b1, 32'h0000_0100, SCR1_MEM_CMD_RD);
    port_req_ack = 3'b001;
    settle();
    chk("t027_preq", 32'(port_req), 32'h1);
    chk("t027_ack", 32'(dmem_req_ack), 32'd1);
    tick();
    req(1'b0, 32'h0000_0100, SCR1_MEM_CMD_RD);
    port_resp[0] = SCR1_MEM_RESP_RDY_OK; port_rdata[0] = 32'hA5;
    settle();
    chk("t027_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_RDY_OK));
    chk("t027_rdata", dmem_rdata, 32'hA5);
    tick();
    settle();
    chk("t027_back_addr", 32'(dmem_resp), 32'(SCR1_MEM_RESP_IDLE));
    tick();

    // Back-to-back: port1 then port0 on the RDY_OK cycle
    ports_idle();
    req(1'b1, 32'hF000_0004, SCR1_MEM_CMD_RD);
    port_req_ack = 3'b010;
    settle();
    chk("t028_preq1", 32'(port_req), 32'h2);
    tick();
    req(1'b1, 32'h0000_0008, SCR1_MEM_CMD_RD);
    port_req_ack = 3'b001;
    port_resp[1] = SCR1_MEM_RESP_RDY_OK; port_rdata[1] = 32'h11;
    settle();
    chk("t028_preq0", 32'(port_req), 32'h1);
    chk("t028_ack", 32'(dmem_req_ack), 32'd1);
    chk("t028_rdata1", dmem_rdata, 32'h11);
    tick();
    req(1'b0, 32'h0000_0008, SCR1_MEM_CMD_RD);
    port_resp[1] = SCR1_MEM_RESP_IDLE;
    port_resp[0] = SCR1_MEM_RESP_RDY_OK; port_rdata[0] = 32'h22;
    settle();
    chk("t028_resp0", 32'(dmem_resp), 32'(SCR1_MEM_RESP_RDY_OK));
    chk("t028_rdata0", dmem_rdata, 32'h22);
    tick();

    // Unmapped write: ack without port request, one-cycle error
    ports_idle();
    req(1'b1, 32'hE000_0000, SCR1_MEM_CMD_WR);
    settle();
    chk("t029_ack", 32'(dmem_req_ack), 32'd1);
    chk("t029_preq", 32'(port_req), 32'h0);
    tick();
    req(1'b1, 32'h0000_0100, SCR1_MEM_CMD_RD);
    port_req_ack = 3'b111;
    for (int i = 0; i < int'(NP); i++) begin
      port_resp[i] = SCR1_MEM_RESP_RDY_OK; port_rdata[i] = 32'hFF;
    end
    settle();
    chk("t029_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_RDY_ER));
    chk("t029_rdata", dmem_rdata, 32'h0);
    chk("t029_err_ack", 32'(dmem_req_ack), 32'd0);
    chk("t029_err_preq", 32'(port_req), 32'h0);
    tick();
    ports_idle();
    req(1'b0, 32'h0000_0100, SCR1_MEM_CMD_RD);
    settle();
    chk("t029_idle", 32'(dmem_resp), 32'(SCR1_MEM_RESP_IDLE));
    tick();

    // Port2 waits three cycles then errors
    req(1'b1, 32'hF004_0010, SCR1_MEM_CMD_RD);
    port_req_ack = 3'b100;
    settle();
    chk("t030_preq", 32'(port_req), 32'h4);
    tick();
    req(1'b1, 32'h0000_0100, SCR1_MEM_CMD_RD);
    port_req_ack = 3'b111;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t030_wait_ack", 32'(dmem_req_ack), 32'd0);
      chk("t030_wait_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_IDLE));
      tick();
    end
    port_resp[2] = SCR1_MEM_RESP_RDY_ER;
    settle();
    chk("t030_er_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_RDY_ER));
    chk("t030_er_ack", 32'(dmem_req_ack), 32'd0);
    chk("t030_er_preq", 32'(port_req), 32'h0);
    tick();
    req(1'b0, 32'h0000_0100, SCR1_MEM_CMD_RD);
    settle();
    chk("t030_addr", 32'(dmem_resp), 32'(SCR1_MEM_RESP_IDLE));
    tick();

    // Overlap: 0xF000_0000 hits port1 and port2, port1 wins
    ports_idle();
    req(1'b1, 32'hF000_0000, SCR1_MEM_CMD_RD);
    port_req_ack = 3'b110;
    settle();
    chk("t032_preq", 32'(port_req), 32'h2);
    tick();

    // Asynchronous reset in the middle of a port1 transaction
    req(1'b1, 32'h0000_0100, SCR1_MEM_CMD_RD);
    port_req_ack = 3'b001;
    port_resp[1] = SCR1_MEM_RESP_RDY_OK; port_rdata[1] = 32'h77;
    #1;
    chk("t031_pre_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_RDY_OK));
    chk("t031_pre_preq", 32'(port_req), 32'h1);
    rst = 1'b1; m_busy = 1'b0; m_err = 1'b0;
    #1;
    chk("t031_rst_preq", 32'(port_req), 32'h0);
    chk("t031_rst_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_IDLE));
    #1;
    rst = 1'b0;
    settle();
    chk("t031_post_preq", 32'(port_req), 32'h1);
    tick();
    req(1'b0, 32'h0000_0100, SCR1_MEM_CMD_RD);
    port_resp[1] = SCR1_MEM_RESP_IDLE;
    port_resp[0] = SCR1_MEM_RESP_RDY_OK; port_rdata[0] = 32'h31;
    settle();
    chk("t031_post_rdata", dmem_rdata, 32'h31);
    tick();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      req($urandom_range(0, 9) < 6, rand_addr(),
          ($urandom_range(0, 1) == 1) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD);
      dmem_width   = type_scr1_mem_y_width_e'(2'($urandom_range(0, 2)));
      dmem_wdata   = $urandom;
      port_req_ack = 3'($urandom);
      for (int i = 0; i < int'(NP); i++) begin
        port_resp[i]  = rand_resp();
        port_rdata[i] = $urandom;
      end
      settle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
